// File: rtl/sample_feeder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sample_feeder_pkg : shared constants, FSM encoding and helpers     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sample_feeder_pkg;

    localparam int unsigned c_INPUT_WIDTH = 3;
    localparam int unsigned c_ADDR_WIDTH  = 14;
    localparam int unsigned c_CLK_DIV     = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_FRST = 3'd2,
        ST_PLAY = 3'd3,
        ST_FCMP = 3'd4,
        ST_DONE = 3'd5
    } feeder_state_t;

    // A requested replay count of zero still plays the block once.
    function automatic logic [7:0] f_norm_passes(input logic [7:0] p);
        return (p == 8'd0) ? 8'd1 : p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_feeder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sample_feeder_if : control, capture and channel-feed signal bundle |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface sample_feeder_if #(
    parameter int INPUT_WIDTH = 3,
    parameter int ADDR_WIDTH  = 14
) ();
    logic                   wr_valid;
    logic [INPUT_WIDTH-1:0] wr_data;
    logic                   wr_ready;
    logic                   start;
    logic                   abort;
    logic [ADDR_WIDTH:0]    length;
    logic [7:0]             passes;
    logic                   busy;
    logic                   done;
    logic [7:0]             pass_count;
    logic                   overflow;
    logic                   clk_sample;
    logic                   sample_valid;
    logic                   feed_reset;
    logic                   feed_complete;
    logic [INPUT_WIDTH-1:0] data;
`ifdef FEEDER_LIVE_EN
    logic                   live;
`endif

    modport master (
        output wr_valid, wr_data, start, abort, length, passes,
`ifdef FEEDER_LIVE_EN
        output live,
`endif
        input  wr_ready, busy, done, pass_count, overflow,
        input  clk_sample, sample_valid, feed_reset, feed_complete, data
    );

    modport slave (
        input  wr_valid, wr_data, start, abort, length, passes,
`ifdef FEEDER_LIVE_EN
        input  live,
`endif
        output wr_ready, busy, done, pass_count, overflow,
        output clk_sample, sample_valid, feed_reset, feed_complete, data
    );
endinterface
`default_nettype wire

// File: rtl/sample_feeder_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sample_feeder_ram : simple dual-port RAM, 1-cycle registered read  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sample_feeder_ram #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 14
) (
    input  wire               clk,
    input  wire               i_we,
    input  wire  [ADDR_W-1:0] i_waddr,
    input  wire  [DATA_W-1:0] i_wdata,
    input  wire               i_re,
    input  wire  [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    // No reset so the array and read register map onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end
endmodule
`default_nettype wire

// File: rtl/sample_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sample_feeder : capture one IF block, replay it N times to channel |
// | Optional live pass-through built when FEEDER_LIVE_EN is defined.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sample_feeder
    import sample_feeder_pkg::*;
#(
    parameter int INPUT_WIDTH = c_INPUT_WIDTH,
    parameter int ADDR_WIDTH  = c_ADDR_WIDTH,
    parameter int CLK_DIV     = c_CLK_DIV
) (
    input wire              clk,
    input wire              global_reset_n,
    sample_feeder_if.slave  bus
);
    localparam int                c_DIV_W    = $clog2(CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(CLK_DIV / 2);

    feeder_state_t          r_state, w_state_nx;
    logic [c_DIV_W-1:0]     r_div;
    logic [ADDR_WIDTH-1:0]  r_lenm1, r_wptr, r_rptr, r_sidx;
    logic [7:0]             r_passes, r_pass_cnt;
    logic                   r_ovf;
    logic [INPUT_WIDTH-1:0] r_data;

    logic                   w_start_ok, w_div_end, w_last_smp, w_pass_last;
    logic                   w_wr_ready, w_we, w_fill_end, w_re, w_load;
    logic                   w_live, w_gap;
    logic [INPUT_WIDTH-1:0] w_rdata, w_next_data;

`ifdef FEEDER_LIVE_EN
    logic                   r_live, r_got;
    logic [INPUT_WIDTH-1:0] r_hold;

    assign w_live      = r_live;
    assign w_gap       = w_load && r_live && !r_got;
    assign w_next_data = r_live ? (r_got ? r_hold : r_data) : w_rdata;

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_live <= 1'b0;
            r_got  <= 1'b0;
            r_hold <= '0;
        end else begin
            if (w_start_ok) begin
                r_live <= bus.live;
                r_got  <= 1'b0;
            end else if (w_load) begin
                r_got  <= 1'b0;
            end
            if (r_live && bus.wr_valid && w_wr_ready) begin
                r_hold <= bus.wr_data;
                r_got  <= 1'b1;
            end
        end
    end
`else
    assign w_live      = 1'b0;
    assign w_gap       = 1'b0;
    assign w_next_data = w_rdata;
`endif

    assign w_start_ok  = bus.start && !bus.abort && (r_state == ST_IDLE) &&
                         (bus.length != '0);
    assign w_div_end   = (r_div == c_DIV_LAST);
    assign w_last_smp  = (r_sidx == r_lenm1);
    assign w_pass_last = ((r_pass_cnt + 8'd1) >= r_passes);
    assign w_wr_ready  = (r_state == ST_FILL) ||
                         (w_live && ((r_state == ST_FRST) || (r_state == ST_PLAY)));
    assign w_we        = bus.wr_valid && (r_state == ST_FILL);
    assign w_fill_end  = w_we && (r_wptr == r_lenm1);
    // Reads run one sample ahead: sample 0 during FRST, sample k+1 in the high phase of k.
    assign w_re        = ((r_state == ST_FRST) && (r_div == '0)) ||
                         ((r_state == ST_PLAY) && (r_div == c_DIV_HALF));
    assign w_load      = ((r_state == ST_FRST) && w_div_end) ||
                         ((r_state == ST_PLAY) && w_div_end && !w_last_smp);

    always_comb begin
        w_state_nx = r_state;
        if (bus.abort) begin
            w_state_nx = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_start_ok) w_state_nx = bus_live_start() ? ST_FRST : ST_FILL;
                ST_FILL: if (w_fill_end) w_state_nx = ST_FRST;
                ST_FRST: if (w_div_end)  w_state_nx = ST_PLAY;
                ST_PLAY: if (w_div_end && w_last_smp) w_state_nx = ST_FCMP;
                ST_FCMP: if (w_div_end)  w_state_nx = w_pass_last ? ST_DONE : ST_FRST;
                ST_DONE: w_state_nx = ST_IDLE;
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    function automatic logic bus_live_start();
`ifdef FEEDER_LIVE_EN
        return bus.live;
`else
        return 1'b0;
`endif
    endfunction

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_div      <= '0;
            r_lenm1    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_sidx     <= '0;
            r_passes   <= 8'd1;
            r_pass_cnt <= 8'd0;
            r_ovf      <= 1'b0;
            r_data     <= '0;
        end else begin
            if ((w_state_nx != r_state) || w_div_end) begin
                r_div <= '0;
            end else if ((r_state == ST_FRST) || (r_state == ST_PLAY) ||
                         (r_state == ST_FCMP)) begin
                r_div <= r_div + c_DIV_W'(1);
            end

            if (w_start_ok) begin
                r_lenm1    <= bus.length[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                r_passes   <= bus_live_start() ? 8'd1 : f_norm_passes(bus.passes);
                r_wptr     <= '0;
                r_pass_cnt <= 8'd0;
            end else if (w_we) begin
                r_wptr <= r_wptr + ADDR_WIDTH'(1);
            end

            if ((w_state_nx == ST_FRST) && (r_state != ST_FRST)) begin
                r_rptr <= '0;
                r_sidx <= '0;
            end else begin
                if (w_re) r_rptr <= r_rptr + ADDR_WIDTH'(1);
                if ((r_state == ST_PLAY) && w_div_end) r_sidx <= r_sidx + ADDR_WIDTH'(1);
            end

            if ((r_state == ST_FCMP) && w_div_end && !bus.abort) begin
                r_pass_cnt <= r_pass_cnt + 8'd1;
            end

            if (w_start_ok) begin
                r_ovf <= 1'b0;
            end else if ((bus.wr_valid && !w_wr_ready) || w_gap) begin
                r_ovf <= 1'b1;
            end

            if (w_load) r_data <= w_next_data;
        end
    end

    sample_feeder_ram #(
        .DATA_W (INPUT_WIDTH),
        .ADDR_W (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (bus.wr_data),
        .i_re    (w_re),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign bus.wr_ready      = w_wr_ready;
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.done          = (r_state == ST_DONE);
    assign bus.pass_count    = r_pass_cnt;
    assign bus.overflow      = r_ovf;
    assign bus.clk_sample    = (r_state == ST_PLAY) && (r_div >= c_DIV_HALF);
    assign bus.sample_valid  = (r_state == ST_PLAY);
    assign bus.feed_reset    = (r_state == ST_FRST);
    assign bus.feed_complete = (r_state == ST_FCMP);
    assign bus.data          = r_data;
endmodule
`default_nettype wire
